// File: rtl/menu_pkg.sv
// Shared encodings for the menu controller and the caption renderer.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_TITLE     = 2'd0,
    ST_SELECT    = 2'd1,
    ST_COUNTDOWN = 2'd2,
    ST_RACE      = 2'd3
  } state_t;

  localparam logic [1:0] CD_START = 2'd3;

endpackage

// File: rtl/menu_ctrl_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag with synchronous clear.
module edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic pend
);

  logic din_d;

  // A new edge wins over clear, so a press on the clearing cycle survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      din_d <= din;
      pend  <= (din & ~din_d) | (pend & ~clr);
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// Frame-synchronous menu sequencer; all renderer-visible outputs move only on frame ticks.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int ITEMS        = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int CD_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       game_over,
  output logic       frame_tick,
  output logic [1:0] state_out,
  output logic [1:0] sel_item,
  output logic       blink_on,
  output logic       menu_en,
  output logic [1:0] countdown,
  output logic       start_game
);

  localparam int MAXF = (BLINK_FRAMES > CD_FRAMES) ? BLINK_FRAMES : CD_FRAMES;
  localparam int CW   = (MAXF > 2) ? $clog2(MAXF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] CD_LAST    = CW'(CD_FRAMES - 1);
  localparam logic [1:0]    ITEM_LAST  = 2'(ITEMS - 1);

  state_t        state, state_n;
  logic [1:0]    sel_n, cd_n;
  logic          blink_n, menu_n, start_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          vsync_d;
  logic          up_p, dn_p, en_p, go_p;
  logic          go_in;

  // game_over only arms in RACE, so a pulse during COUNTDOWN never carries over.
  assign go_in = game_over & (state == ST_RACE);

  edge_latch u_up (.clk(clk), .rst(rst), .din(btn_up),    .clr(frame_tick), .pend(up_p));
  edge_latch u_dn (.clk(clk), .rst(rst), .din(btn_down),  .clr(frame_tick), .pend(dn_p));
  edge_latch u_en (.clk(clk), .rst(rst), .din(btn_enter), .clr(frame_tick), .pend(en_p));
  edge_latch u_go (.clk(clk), .rst(rst), .din(go_in),     .clr(frame_tick), .pend(go_p));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d    <= 1'b0;
      frame_tick <= 1'b0;
      state      <= ST_TITLE;
      sel_item   <= '0;
      blink_on   <= 1'b1;
      menu_en    <= 1'b1;
      countdown  <= '0;
      start_game <= 1'b0;
      cnt        <= '0;
    end else begin
      vsync_d    <= vsync_in;
      frame_tick <= vsync_in & ~vsync_d;
      state      <= state_n;
      sel_item   <= sel_n;
      blink_on   <= blink_n;
      menu_en    <= menu_n;
      countdown  <= cd_n;
      start_game <= start_n;
      cnt        <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_item;
    blink_n = blink_on;
    cd_n    = countdown;
    cnt_n   = cnt;
    start_n = 1'b0;
    if (frame_tick) begin
      unique case (state)
        ST_TITLE: begin
          if (en_p) begin
            state_n = ST_SELECT;
            sel_n   = '0;
            cnt_n   = '0;
            blink_n = 1'b1;
          end else if (cnt == BLINK_LAST) begin
            cnt_n   = '0;
            blink_n = ~blink_on;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_SELECT: begin
          if (en_p) begin
            state_n = ST_COUNTDOWN;
            cd_n    = CD_START;
            cnt_n   = '0;
            blink_n = 1'b1;
          end else if (up_p && !dn_p) begin
            sel_n   = (sel_item == '0) ? ITEM_LAST : sel_item - 2'd1;
            cnt_n   = '0;
            blink_n = 1'b1;
          end else if (dn_p && !up_p) begin
            sel_n   = (sel_item == ITEM_LAST) ? '0 : sel_item + 2'd1;
            cnt_n   = '0;
            blink_n = 1'b1;
          end else if (cnt == BLINK_LAST) begin
            cnt_n   = '0;
            blink_n = ~blink_on;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          blink_n = 1'b1;
          if (cnt == CD_LAST) begin
            cnt_n = '0;
            if (countdown == 2'd1) begin
              state_n = ST_RACE;
              cd_n    = '0;
              start_n = 1'b1;
              blink_n = 1'b0;
            end else begin
              cd_n = countdown - 2'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_RACE: begin
          blink_n = 1'b0;
          if (go_p) begin
            state_n = ST_TITLE;
            sel_n   = '0;
            cnt_n   = '0;
            blink_n = 1'b1;
          end
        end
        default: state_n = ST_TITLE;
      endcase
    end
    menu_n = (state_n != ST_RACE);
  end

  assign state_out = state;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with short blink/countdown periods.
module tb_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst, vsync_in, btn_up, btn_down, btn_enter, game_over;
  logic       frame_tick, blink_on, menu_en, start_game;
  logic [1:0] state_out, sel_item, countdown;
  logic       ft1, ft2, sg1, sg2;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  menu_ctrl #(.ITEMS(3), .BLINK_FRAMES(2), .CD_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .game_over(game_over), .frame_tick(frame_tick), .state_out(state_out),
    .sel_item(sel_item), .blink_on(blink_on), .menu_en(menu_en),
    .countdown(countdown), .start_game(start_game)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: vsync high 3 cycles; optional enter press coincident with frame_tick.
  task automatic tick(input logic enter_at_ft);
    vsync_in = 1'b1;
    @(negedge clk);
    ft1 = frame_tick;
    if (enter_at_ft) btn_enter = 1'b1;
    @(negedge clk);
    ft2 = frame_tick;
    sg1 = start_game;
    btn_enter = 1'b0;
    @(negedge clk);
    sg2 = start_game;
    vsync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic e);
    btn_up = u; btn_down = d; btn_enter = e;
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; vsync_in = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    btn_enter = 1'b0; game_over = 1'b0;
    repeat (2) @(negedge clk);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    vsync_in = 1'b0;
    check("rst_ft",    4'(frame_tick), 4'd0);
    check("rst_state", 4'(state_out),  4'd0);
    check("rst_sel",   4'(sel_item),   4'd0);
    check("rst_blink", 4'(blink_on),   4'd1);
    check("rst_menu",  4'(menu_en),    4'd1);
    check("rst_cd",    4'(countdown),  4'd0);
    check("rst_sg",    4'(start_game), 4'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // TITLE blink with period 2
    check("ft_idle", 4'(frame_tick), 4'd0);
    tick(1'b0);
    check("ft_lat1", 4'(ft1), 4'd1);
    check("ft_width", 4'(ft2), 4'd0);
    check("blink_t1", 4'(blink_on), 4'd1);
    tick(1'b0);
    check("blink_t2", 4'(blink_on), 4'd0);
    tick(1'b0);
    check("blink_t3", 4'(blink_on), 4'd0);
    tick(1'b0);
    check("blink_t4", 4'(blink_on), 4'd1);

    // mid-frame enter takes effect at next tick
    press(1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("mid_hold", 4'(state_out), 4'd0);
    tick(1'b0);
    check("to_select", 4'(state_out), 4'd1);
    check("sel_init",  4'(sel_item),  4'd0);

    // wrap-around
    press(1'b1, 1'b0, 1'b0); tick(1'b0);
    check("up_wrap", 4'(sel_item), 4'd2);
    press(1'b0, 1'b1, 1'b0); tick(1'b0);
    check("dn_wrap", 4'(sel_item), 4'd0);
    press(1'b0, 1'b1, 1'b0); tick(1'b0);
    check("dn_1", 4'(sel_item), 4'd1);
    tick(1'b0);
    check("sel_blink_a", 4'(blink_on), 4'd1);
    tick(1'b0);
    check("sel_blink_b", 4'(blink_on), 4'd0);
    press(1'b1, 1'b1, 1'b0); tick(1'b0);
    check("updn_sel",   4'(sel_item), 4'd1);
    check("updn_blink", 4'(blink_on), 4'd0);
    press(1'b0, 1'b1, 1'b0); tick(1'b0);
    check("chg_sel",   4'(sel_item), 4'd2);
    check("chg_blink", 4'(blink_on), 4'd1);
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0);
    tick(1'b0);
    check("multi_once", 4'(sel_item), 4'd0);

    // enter coincident with frame_tick lands one frame later
    tick(1'b1);
    check("coinc_hold", 4'(state_out), 4'd1);
    tick(1'b0);
    check("to_cd",    4'(state_out), 4'd2);
    check("cd_start", 4'(countdown), 4'd3);
    check("cd_menu",  4'(menu_en),   4'd1);
    check("cd_blink", 4'(blink_on),  4'd1);
    repeat (3) tick(1'b0);
    check("cd3_last", 4'(countdown), 4'd3);
    tick(1'b0);
    check("cd2", 4'(countdown), 4'd2);
    press(1'b0, 1'b1, 1'b0); tick(1'b0);
    check("cd_frozen", 4'(sel_item), 4'd0);
    repeat (3) tick(1'b0);
    check("cd1", 4'(countdown), 4'd1);
    game_over = 1'b1; @(negedge clk); game_over = 1'b0;
    repeat (3) tick(1'b0);
    check("cd1_last", 4'(countdown), 4'd1);
    check("pre_sg",   4'(sg1),       4'd0);
    tick(1'b0);
    check("race",      4'(state_out), 4'd3);
    check("sg_on",     4'(sg1),       4'd1);
    check("sg_off",    4'(sg2),       4'd0);
    check("race_menu", 4'(menu_en),   4'd0);
    check("race_cd",   4'(countdown), 4'd0);
    check("race_blink",4'(blink_on),  4'd0);
    tick(1'b0);
    check("go_discard", 4'(state_out), 4'd3);
    game_over = 1'b1; @(negedge clk); game_over = 1'b0;
    tick(1'b0);
    check("go_title", 4'(state_out), 4'd0);
    check("go_menu",  4'(menu_en),   4'd1);

    // async reset in COUNTDOWN with countdown=2
    press(1'b0, 1'b0, 1'b1); tick(1'b0);
    press(1'b0, 1'b0, 1'b1); tick(1'b0);
    repeat (4) tick(1'b0);
    check("ar_cd2", 4'(countdown), 4'd2);
    #2 rst = 1'b0;
    #1;
    check("ar_state", 4'(state_out), 4'd0);
    check("ar_cd",    4'(countdown), 4'd0);
    check("ar_menu",  4'(menu_en),   4'd1);
    check("ar_blink", 4'(blink_on),  4'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
- Frame-synchronous controller for the menu caption overlay.
- Sits beside the two-stage VGA timing delay that feeds the caption renderer, and consumes the undelayed vsync from the timing generator.
- Sequences menu screens (title, item select, start countdown, race) from button inputs and a game-over event.
- Every output the renderer sees changes only on a frame boundary, so captions never tear mid-frame.

Parameters:
- ITEMS, 3, number of selectable menu items (2..4); sel_item encodes 0..ITEMS-1.
- BLINK_FRAMES, 30, frames per blink half-period.
- CD_FRAMES, 60, frames per countdown step.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- vsync_in  in  1  vsync from the timing generator, active high.
- btn_up  in  1  debounced, clk-synchronous level.
- btn_down  in  1  debounced, clk-synchronous level.
- btn_enter  in  1  debounced, clk-synchronous level.
- game_over  in  1  single-cycle pulse from game logic.
- frame_tick  out  1  one-cycle pulse per frame.
- state_out  out  2  encoding 0=TITLE, 1=SELECT, 2=COUNTDOWN, 3=RACE.
- sel_item  out  2  highlighted menu item.
- blink_on  out  1  blink phase for the highlighted caption.
- menu_en  out  1  caption overlay enable.
- countdown  out  2  countdown digit 3..1; 0 when not counting.
- start_game  out  1  one-cycle pulse on entering RACE.

Behaviour:
- Reset (rst low, asynchronous): TITLE; sel_item=0, blink_on=1, menu_en=1, countdown=0, start_game=0, frame_tick=0. All counters, latches and edge registers clear; vsync_d=0. Reset mid-operation from any state returns to TITLE.
- Frame tick: vsync_d <= vsync_in. frame_tick is registered: asserted on the cycle after the clk edge that sees vsync_in=1 and vsync_d=0. All state, sel_item, blink_on, menu_en, countdown and start_game updates occur only on the clk edge where frame_tick=1, so they are visible one cycle after the frame_tick pulse.
- Button capture: rising-edge detect per button. Each edge sets a sticky latch (up_p, dn_p, en_p, go_p). All latches clear on the frame_tick edge after evaluation. A latch set in the same cycle as frame_tick carries over to the next frame. Multiple presses in one frame count once.
- Priority at evaluation: en_p, then up_p/dn_p. If up_p and dn_p are both set without en_p, both are ignored.
- Blink: 6-bit frame counter. blink_on toggles every BLINK_FRAMES ticks in TITLE and SELECT. Counter resets and blink_on=1 on every state change and every sel_item change.
- TITLE: menu_en=1. en_p moves to SELECT with sel_item=0.
- SELECT: menu_en=1.
  - up_p: sel_item = sel_item-1, wraps from 0 to ITEMS-1.
  - dn_p: sel_item+1, wraps from ITEMS-1 to 0.
  - en_p: moves to COUNTDOWN with countdown=3 and frame counter=0; sel_item is frozen.
- COUNTDOWN: menu_en=1, blink_on=1, buttons ignored (latches still cleared).
  - Each CD_FRAMES ticks, countdown decrements.
  - On the tick where countdown=1 and the counter expires: go to RACE, countdown=0, start_game=1 for exactly one cycle.
- RACE: menu_en=0, blink_on=0, buttons ignored.
  - go_p at a tick moves to TITLE, sel_item=0.
  - game_over arriving during COUNTDOWN is discarded, not carried into RACE.
- Counters are sized ceil(log2(max(BLINK_FRAMES, CD_FRAMES))) bits and compare with equality against PARAM-1.
- No combinational path from any input to any output.

Decomposition:
- Shared package menu_pkg holds:
  - state encodings ST_TITLE=0, ST_SELECT=1, ST_COUNTDOWN=2, ST_RACE=3, shared with the caption renderer;
  - CD_START=3.
- Sub-module edge_latch: rising-edge detect plus sticky latch with synchronous clear. Instantiated 4x (three buttons plus game_over).

Test Plan:
- Reset check: hold rst=0 for 5 cycles, drive vsync every 1000 cycles. → state_out=0, sel_item=0, blink_on=1, menu_en=1, countdown=0. First frame_tick appears exactly 1 cycle after the first vsync rising edge.
- Frame alignment: press btn_enter mid-frame. → state_out unchanged until the next frame_tick, then 1 (SELECT) one cycle later. A press coincident with frame_tick takes effect one frame later.
- Wrap-around with ITEMS=3: in SELECT, btn_up once. → sel_item 0→2. Then btn_down twice across two frames → 2→0→1. Up and down together in one frame → sel_item unchanged.
- Countdown: enter in SELECT with CD_FRAMES=4.
  - Expected: countdown=3 for 4 ticks, then 2, then 1.
  - Then state_out=3 and start_game high for exactly 1 cycle; menu_en=0.
- Blink with BLINK_FRAMES=2: in TITLE, blink_on toggles every 2 frame ticks. A sel_item change restarts the phase with blink_on=1.
- Async reset in COUNTDOWN (countdown=2): assert rst mid-frame, no clock edge required. → outputs return to reset values immediately. game_over pulse in RACE → TITLE at the next tick.
